// File: rtl/store_pkg.sv
// Shared types for the store alignment path: store size encoding and
// the beat-sequencing state machine states.
package store_pkg;

    typedef enum logic [1:0] {
        ST_BYTE = 2'b00,
        ST_HALF = 2'b01,
        ST_WORD = 2'b10
    } store_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } state_e;

    localparam logic [1:0] ST_RSVD = 2'b11;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering for stores.
// Ports: i_data (rs2 value), i_off (addr[1:0]), i_type (funct3[1:0]);
//        o_ext_data (data shifted into a 2-word window), o_ext_mask (byte enables).
module store_lane_align
    import store_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_type,
    output logic [63:0] o_ext_data,
    output logic [7:0]  o_ext_mask
);

    logic [31:0] w_data;
    logic [3:0]  w_size;

    always_comb begin
        w_data = '0;
        w_size = '0;
        case (i_type)
            ST_BYTE: begin
                w_data = {24'd0, i_data[7:0]};
                w_size = 4'b0001;
            end
            ST_HALF: begin
                w_data = {16'd0, i_data[15:0]};
                w_size = 4'b0011;
            end
            ST_WORD: begin
                w_data = i_data;
                w_size = 4'b1111;
            end
            default: begin
                w_data = '0;
                w_size = '0;
            end
        endcase
        // Shifting through a 64-bit window lets the upper half become the
        // second beat of a store that crosses a word boundary.
        o_ext_data = {32'd0, w_data} << {i_off, 3'b000};
        o_ext_mask = {4'd0, w_size} << i_off;
    end

endmodule

// File: rtl/store_align_unit.sv
// Store data path: accepts a store request, aligns data into byte lanes and
// issues one or two word-aligned write beats over a valid/ready handshake.
// Ports: i_req_* / o_req_ready (request side), o_mem_* / i_mem_ready (memory
//        write port), o_done / o_err (one-cycle completion / reserved-type pulses).
module store_align_unit
    import store_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_store_type,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_done,
    output logic        o_err
);

    state_e      r_state;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_bmask;
    logic [31:0] r_hi_data;
    logic [3:0]  r_hi_mask;
    logic        r_done;
    logic        r_err;

    logic [63:0] w_ext_data;
    logic [7:0]  w_ext_mask;
    logic        w_accept;

    store_lane_align u_lane (
        .i_data     (i_store_data),
        .i_off      (i_addr[1:0]),
        .i_type     (i_store_type),
        .o_ext_data (w_ext_data),
        .o_ext_mask (w_ext_mask)
    );

    assign w_accept = (r_state == IDLE) && i_req_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_bmask <= '0;
            r_hi_data   <= '0;
            r_hi_mask   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (i_store_type == ST_RSVD) begin
                            r_err <= 1'b1;
                        end else begin
                            // Beat 0 is staged now; the upper half waits
                            // in r_hi_* in case the store spills over.
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {i_addr[31:2], 2'b00};
                            r_mem_wdata <= w_ext_data[31:0];
                            r_mem_bmask <= w_ext_mask[3:0];
                            r_hi_data   <= w_ext_data[63:32];
                            r_hi_mask   <= w_ext_mask[7:4];
                            r_state     <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (i_mem_ready) begin
                        if (r_hi_mask != 4'd0) begin
                            r_mem_addr  <= r_mem_addr + 32'd4;
                            r_mem_wdata <= r_hi_data;
                            r_mem_bmask <= r_hi_mask;
                            r_state     <= BEAT1;
                        end else begin
                            r_mem_valid <= 1'b0;
                            r_mem_addr  <= '0;
                            r_mem_wdata <= '0;
                            r_mem_bmask <= '0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                BEAT1: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_bmask <= '0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_bmask = r_mem_bmask;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
